sequenciador_partida: RTL

SEQUENCIADOR_PARTIDA -- requirements
Module: sequenciador_partida

---
 rtl/sequenciador_partida.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sequenciador_partida.sv
// sequenciador_partida: game-flow controller for the move/score datapath.
// Moore FSM; every control output is a register loaded from the next-state
// decode, so outputs always reflect the state register's current value.
module sequenciador_partida #(
    parameter int N_RODADAS = 10,
    parameter int MAX_ERROS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       terminar,
    input  logic       temJogada,
    input  logic       acertou,
    input  logic       fimT,
    output logic       zeraT,
    output logic       zeraR,
    output logic       zeraP,
    output logic       contaT,
    output logic       contaP,
    output logic       decresceT,
    output logic       registraR,
    output logic       geraNova,
    output logic       fimJogo,
    output logic       ganhou,
    output logic [3:0] db_estado,
    output logic [3:0] db_rodada,
    output logic [1:0] db_erros
);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        GERA     = 4'd2,
        ESPERA   = 4'd3,
        REGISTRA = 4'd4,
        COMPARA  = 4'd5,
        ACERTO   = 4'd6,
        ERRO     = 4'd7,
        PROXIMA  = 4'd8,
        FIM      = 4'd9
    } estado_t;

    localparam logic [3:0] RODADAS_FIM = 4'(N_RODADAS);
    localparam logic [1:0] ERROS_FIM   = 2'(MAX_ERROS);

    estado_t    estado;
    estado_t    proximo;
    logic [3:0] rodada;
    logic [1:0] erros;
    logic       fim_rodadas;
    logic       fim_erros;

    assign fim_rodadas = (rodada == RODADAS_FIM);
    assign fim_erros   = (erros == ERROS_FIM);

    // Next-state selection from the current state and sampled inputs
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:  if (iniciar) proximo = PREPARA;
            PREPARA:  proximo = GERA;
            GERA:     proximo = ESPERA;
            ESPERA: begin
                if (terminar)       proximo = FIM;
                else if (fimT)      proximo = ERRO;
                else if (temJogada) proximo = REGISTRA;
            end
            REGISTRA: proximo = COMPARA;
            COMPARA:  proximo = acertou ? ACERTO : ERRO;
            ACERTO:   proximo = PROXIMA;
            ERRO:     proximo = PROXIMA;
            PROXIMA: begin
                if (fim_erros)        proximo = FIM;
                else if (fim_rodadas) proximo = FIM;
                else                  proximo = GERA;
            end
            FIM:      if (iniciar) proximo = PREPARA;
            default:  proximo = INICIAL;
        endcase
    end

    // State, counters, result flag and registered output decode
    // Counter and output updates are keyed on the state being entered, so
    // they become visible in the same cycle as the state that causes them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            rodada    <= '0;
            erros     <= '0;
            ganhou    <= 1'b0;
            zeraT     <= 1'b0;
            zeraR     <= 1'b0;
            zeraP     <= 1'b0;
            contaT    <= 1'b0;
            contaP    <= 1'b0;
            decresceT <= 1'b0;
            registraR <= 1'b0;
            geraNova  <= 1'b0;
            fimJogo   <= 1'b0;
        end else begin
            estado    <= proximo;
            zeraT     <= (proximo == PREPARA);
            zeraR     <= (proximo == PREPARA) || (proximo == PROXIMA);
            zeraP     <= (proximo == PREPARA);
            contaT    <= (proximo == ESPERA);
            contaP    <= (proximo == ACERTO);
            decresceT <= (proximo == ERRO);
            registraR <= (proximo == REGISTRA);
            geraNova  <= (proximo == GERA);
            fimJogo   <= (proximo == FIM);

            case (proximo)
                PREPARA: begin
                    rodada <= '0;
                    erros  <= '0;
                    ganhou <= 1'b0;
                end
                ACERTO: begin
                    if (rodada < RODADAS_FIM) rodada <= rodada + 4'd1;
                end
                ERRO: begin
                    if (rodada < RODADAS_FIM) rodada <= rodada + 4'd1;
                    if (erros < ERROS_FIM)    erros  <= erros + 2'd1;
                end
                FIM: begin
                    // Only the transition into FIM writes the result; holding leaves it.
                    if (estado == PROXIMA)
                        ganhou <= fim_rodadas && !fim_erros;
                    else if (estado == ESPERA)
                        ganhou <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign db_estado = estado;
    assign db_rodada = rodada;
    assign db_erros  = erros;

endmodule
